// File: rtl/playfield_writer_pkg.sv
// playfield_writer_pkg: shared constants and types for the playfield write engine
// Holds the CPU I/O region code, register offsets, STATUS bit positions and FSM states.
package playfield_writer_pkg;
  localparam logic [1:0] IO_REGION = 2'h2;
  localparam logic [1:0] PF_PTR    = 2'd0;
  localparam logic [1:0] PF_DATA   = 2'd1;
  localparam logic [1:0] PF_STATUS = 2'd2;
  localparam logic [1:0] PF_FILL   = 2'd3;
  localparam int ST_LEVEL_W = 5;
  localparam int ST_FILL    = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_OVF     = 15;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;
endpackage

// File: rtl/pf_write_fifo.sv
// pf_write_fifo: show-ahead synchronous FIFO holding queued {addr,data} playfield writes
// Ports: clk_i/rst_i clock and sync reset; push_i/wdata_i enqueue; pop_i dequeue;
// rdata_o head entry; level_o occupancy; full_o/empty_o flags.
module pf_write_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          do_pop, do_push;
  assign empty_o = level_q == '0;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot, so a push at full is still taken
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/playfield_writer.sv
// playfield_writer: queues CPU tile writes and commits them (or a full-screen fill) during vblank
// Ports: i_Clk/reset clock and sync reset; io_sel/cpu_write/cpu_addr/cpu_wr_data CPU register
// writes; cpu_rd_data register reads; row beam row; pf_write/pf_write_addr/pf_wr_data RAM write
// port; busy queue non-empty or fill running.
module playfield_writer
  import playfield_writer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [9:0] V_ACTIVE   = 10'd480
) (
  input  logic        i_Clk,
  input  logic        reset,
  input  logic        io_sel,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_wr_data,
  output logic [15:0] cpu_rd_data,
  input  logic [9:0]  row,
  output logic        pf_write,
  output logic [9:0]  pf_write_addr,
  output logic [7:0]  pf_wr_data,
  output logic        busy
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_e      state_q;
  logic [9:0]  ptr_q, fill_cnt_q, pf_addr_q;
  logic [7:0]  fill_val_q, pf_data_q;
  logic        ovf_q, pf_write_q;
  logic [17:0] head;
  logic [LW-1:0] level;
  logic        full, empty, vblank, wr, enq, fill_req, fill_ok, pop, drop;
  logic [15:0] status;
  logic        unused_wr_bits;
  assign unused_wr_bits = ^cpu_wr_data[15:10];
  assign vblank   = row >= V_ACTIVE;
  assign wr       = io_sel & cpu_write;
  assign enq      = wr & (cpu_addr == PF_DATA);
  assign fill_req = wr & (cpu_addr == PF_FILL);
  assign pop      = (state_q == IDLE) & ~empty & vblank;
  // a fill may only start with nothing queued, so it never interleaves with FIFO entries
  assign fill_ok  = (state_q == IDLE) & empty;
  assign drop     = enq & full & ~pop;
  pf_write_fifo #(.W(18), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_Clk),
    .rst_i   (reset),
    .push_i  (enq),
    .pop_i   (pop),
    .wdata_i ({ptr_q, cpu_wr_data[7:0]}),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );
  always_comb begin
    status = '0;
    status[ST_LEVEL_W-1:0] = ST_LEVEL_W'(level);
    status[ST_FILL] = state_q == FILL;
    status[ST_FULL] = full;
    status[ST_OVF]  = ovf_q;
  end
  assign cpu_rd_data = !io_sel ? 16'h0 :
                       cpu_addr == PF_PTR    ? {6'b0, ptr_q} :
                       cpu_addr == PF_STATUS ? status : 16'h0;
  assign pf_write      = pf_write_q;
  assign pf_write_addr = pf_addr_q;
  assign pf_wr_data    = pf_data_q;
  assign busy          = ~empty | (state_q == FILL);
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      fill_cnt_q <= '0;
      fill_val_q <= '0;
      ovf_q      <= 1'b0;
      pf_write_q <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
    end else begin
      if (wr & (cpu_addr == PF_PTR)) ptr_q <= cpu_wr_data[9:0];
      else if (enq) ptr_q <= ptr_q + 10'd1;
      if (wr & (cpu_addr == PF_STATUS)) ovf_q <= 1'b0;
      else if (drop | (fill_req & ~fill_ok)) ovf_q <= 1'b1;
      pf_write_q <= 1'b0;
      if (state_q == IDLE) begin
        if (pop) begin
          pf_write_q <= 1'b1;
          pf_addr_q  <= head[17:8];
          pf_data_q  <= head[7:0];
        end else if (fill_req & fill_ok) begin
          state_q    <= FILL;
          fill_cnt_q <= '0;
          fill_val_q <= cpu_wr_data[7:0];
        end
      end else if (vblank) begin
        pf_write_q <= 1'b1;
        pf_addr_q  <= fill_cnt_q;
        pf_data_q  <= fill_val_q;
        fill_cnt_q <= fill_cnt_q + 10'd1;
        if (fill_cnt_q == 10'd1023) state_q <= IDLE;
      end
    end
  end
endmodule
